// File: rtl/jpc_ifetch_pq.sv
// Prefetching instruction fetch unit: streams sequential fetches with up to MAX_OUT
// requests in flight, buffers PC-tagged words in a prefetch FIFO, flushes on redirect.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif
`ifndef JPC_INSTRUCTION_WIDTH
`define JPC_INSTRUCTION_WIDTH 32
`endif

// state | meaning
// IDLE  | out of reset, waiting for the first PC
// FETCH | streaming sequential fetches; a further PC is a redirect
module jpc_ifetch_pq #(
  parameter int ADDR_W  = `JPC_ADDRESS_WIDTH,
  parameter int INSTR_W = `JPC_INSTRUCTION_WIDTH,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2,
  parameter int STEP    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          pc_I,
  input  logic                       pc_valid_I,
  output logic                       pc_ready_O,
  output logic [INSTR_W-1:0]         instr_O,
  output logic [ADDR_W-1:0]          instr_pc_O,
  output logic                       instr_valid_O,
  input  logic                       instr_ready_I,
  output logic [ADDR_W-1:0]          mem_addr_O,
  output logic                       mem_addr_valid_O,
  input  logic                       mem_addr_ready_I,
  input  logic [INSTR_W-1:0]         mem_data_I,
  input  logic                       mem_data_valid_I,
  output logic                       mem_data_ready_O,
  output logic [$clog2(DEPTH):0]     count_O
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t              state, state_nx;
  logic                ready_q;
  logic [ADDR_W-1:0]   fetch_pc, resp_pc, new_pc;
  logic [CW-1:0]       count, outstanding, drop, live, out_nx;
  logic [CW:0]         credit;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [INSTR_W-1:0]  fifo_instr [DEPTH];
  logic [ADDR_W-1:0]   fifo_pc    [DEPTH];
  logic [INSTR_W-1:0]  last_instr;
  logic [ADDR_W-1:0]   last_pc;
  logic                pc_hs, addr_hs, data_hs, push, pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == IDLE && pc_hs) state_nx = FETCH;
  end

  // Credit counts live in-flight words so every accepted response has a FIFO slot.
  always_comb begin
    live             = outstanding - drop;
    credit           = {1'b0, count} + {1'b0, live};
    mem_addr_valid_O = 1'b0;
    if (state == FETCH)
      mem_addr_valid_O = (outstanding < CW'(MAX_OUT)) && (credit < (CW+1)'(DEPTH));
  end

  assign pc_ready_O       = ready_q;
  assign mem_data_ready_O = ready_q;
  assign mem_addr_O       = fetch_pc;
  assign count_O          = count;
  assign instr_valid_O    = (count != '0);
  assign instr_O          = instr_valid_O ? fifo_instr[rd_ptr] : last_instr;
  assign instr_pc_O       = instr_valid_O ? fifo_pc[rd_ptr]    : last_pc;

  assign new_pc  = {pc_I[ADDR_W-1:2], 2'b00};
  assign pc_hs   = pc_valid_I & ready_q;
  assign addr_hs = mem_addr_valid_O & mem_addr_ready_I;
  assign data_hs = mem_data_valid_I & ready_q & (outstanding != '0);
  assign pop     = instr_valid_O & instr_ready_I;
  assign push    = data_hs & ~pc_hs & (drop == '0);
  assign out_nx  = outstanding + CW'(addr_hs) - CW'(data_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      fetch_pc    <= '0;
      resp_pc     <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_instr  <= '0;
      last_pc     <= '0;
    end else begin
      ready_q     <= 1'b1;
      outstanding <= out_nx;
      last_instr  <= instr_O;
      last_pc     <= instr_pc_O;
      if (pc_hs) begin
        // Everything still in flight after this edge belongs to the old stream.
        fetch_pc <= new_pc;
        resp_pc  <= new_pc;
        drop     <= out_nx;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (addr_hs) fetch_pc <= fetch_pc + STEP_V;
        if (data_hs && drop != '0) drop <= drop - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          resp_pc <= resp_pc + STEP_V;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= mem_data_I;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_jpc_ifetch_pq.sv
// Bench for jpc_ifetch_pq: 1-cycle memory model, vector table for PC loads, plus
// hand sequences for reset, backpressure, redirect drop and same-cycle response.
module tb_jpc_ifetch_pq;

  logic        clk, rst_n;
  logic [31:0] pc_I, instr_O, instr_pc_O, mem_addr_O, mem_data_I;
  logic        pc_valid_I, pc_ready_O, instr_valid_O, instr_ready_I;
  logic        mem_addr_valid_O, mem_addr_ready_I, mem_data_valid_I, mem_data_ready_O;
  logic [2:0]  count_O;

  jpc_ifetch_pq #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .MAX_OUT(2), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_I(pc_I), .pc_valid_I(pc_valid_I), .pc_ready_O(pc_ready_O),
    .instr_O(instr_O), .instr_pc_O(instr_pc_O), .instr_valid_O(instr_valid_O),
    .instr_ready_I(instr_ready_I),
    .mem_addr_O(mem_addr_O), .mem_addr_valid_O(mem_addr_valid_O),
    .mem_addr_ready_I(mem_addr_ready_I),
    .mem_data_I(mem_data_I), .mem_data_valid_I(mem_data_valid_I),
    .mem_data_ready_O(mem_data_ready_O),
    .count_O(count_O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } deliv_t;
  typedef struct { logic [31:0] pc_in; logic [31:0] exp_addr; logic [31:0] exp_next; } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rsp_q[$];
  logic [31:0] issued[$];
  deliv_t      got[$];
  bit          resp_en;
  bit          last_data_hs;
  int          out_cnt, max_out_seen;
  vec_t        vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a == 32'h0) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [31:0] got_pc(input int i);
    return (got.size() > i) ? got[i].pc : 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] got_instr(input int i);
    return (got.size() > i) ? got[i].instr : 32'hBAD0_BAD0;
  endfunction

  // One clock: present the memory response, observe handshakes at negedge, step past posedge.
  task automatic tick();
    bit hs_a, hs_d;
    deliv_t d;
    mem_data_valid_I = resp_en && (rsp_q.size() > 0);
    mem_data_I       = (rsp_q.size() > 0) ? rsp_q[0] : 32'h0;
    @(negedge clk);
    hs_a = mem_addr_valid_O && mem_addr_ready_I;
    hs_d = mem_data_valid_I && mem_data_ready_O;
    if (instr_valid_O && instr_ready_I) begin
      d.instr = instr_O;
      d.pc    = instr_pc_O;
      got.push_back(d);
    end
    if (hs_a) begin
      rsp_q.push_back(word_at(mem_addr_O));
      issued.push_back(mem_addr_O);
    end
    if (hs_d) rsp_q.delete(0);
    out_cnt = out_cnt + (hs_a ? 1 : 0) - (hs_d ? 1 : 0);
    if (out_cnt > max_out_seen) max_out_seen = out_cnt;
    last_data_hs = hs_d;
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] v);
    pc_I       = v;
    pc_valid_I = 1'b1;
    chk("pc_ready_at_redirect", 32'(pc_ready_O), 32'd1);
    tick();
    pc_valid_I = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 32'(got.size() >= n), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{pc_in: 32'h0000_0000, exp_addr: 32'h0000_0000, exp_next: 32'h0000_0004};
    vecs[1] = '{pc_in: 32'h0000_0010, exp_addr: 32'h0000_0010, exp_next: 32'h0000_0014};
    vecs[2] = '{pc_in: 32'h0000_0023, exp_addr: 32'h0000_0020, exp_next: 32'h0000_0024};
    vecs[3] = '{pc_in: 32'hFFFF_FFFC, exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};
    vecs[4] = '{pc_in: 32'h0000_0081, exp_addr: 32'h0000_0080, exp_next: 32'h0000_0084};

    rst_n = 1'b0; pc_I = '0; pc_valid_I = 1'b0; instr_ready_I = 1'b1;
    mem_addr_ready_I = 1'b1; mem_data_I = '0; mem_data_valid_I = 1'b0;
    resp_en = 1'b1; out_cnt = 0; max_out_seen = 0; last_data_hs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_ready", 32'(pc_ready_O), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid_O), 32'd0);
    chk("rst_addr_valid", 32'(mem_addr_valid_O), 32'd0);
    chk("rst_count", 32'(count_O), 32'd0);
    chk("rst_instr", instr_O, 32'd0);
    chk("rst_mem_addr", mem_addr_O, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_pc_ready", 32'(pc_ready_O), 32'd1);
    chk("idle_addr_valid", 32'(mem_addr_valid_O), 32'd0);

    // PC load table: alignment, wrap, first word and its successor
    for (int i = 0; i < 5; i++) begin
      redirect(vecs[i].pc_in);
      got.delete();
      issued.delete();
      chk("vec_mem_addr", mem_addr_O, vecs[i].exp_addr);
      run_until(2, 20, "vec_timeout");
      chk("vec_first_issue", (issued.size() > 0) ? issued[0] : 32'hBAD0_BAD0, vecs[i].exp_addr);
      chk("vec_pc0", got_pc(0), vecs[i].exp_addr);
      chk("vec_instr0", got_instr(0), word_at(vecs[i].exp_addr));
      chk("vec_pc1", got_pc(1), vecs[i].exp_next);
      chk("vec_instr1", got_instr(1), word_at(vecs[i].exp_next));
    end
    chk("max_outstanding", 32'(max_out_seen <= 2), 32'd1);

    // Backpressure: fill, stall issue, then drain without loss or duplication
    instr_ready_I = 1'b0;
    redirect(32'h100);
    got.delete();
    repeat (12) tick();
    chk("bp_count_full", 32'(count_O), 32'd4);
    chk("bp_no_issue", 32'(mem_addr_valid_O), 32'd0);
    chk("bp_head_pc", instr_pc_O, 32'h100);
    chk("bp_head_instr", instr_O, word_at(32'h100));
    instr_ready_I = 1'b1;
    run_until(8, 40, "bp_drain_timeout");
    for (int i = 0; i < 8; i++) begin
      chk("bp_seq_pc", got_pc(i), 32'h100 + 32'(4 * i));
      chk("bp_seq_instr", got_instr(i), word_at(32'h100 + 32'(4 * i)));
    end

    // Redirect flushes a full FIFO
    instr_ready_I = 1'b0;
    repeat (10) tick();
    chk("flush_pre_full", 32'(count_O), 32'd4);
    redirect(32'h300);
    chk("flush_count", 32'(count_O), 32'd0);
    chk("flush_instr_valid", 32'(instr_valid_O), 32'd0);

    // Two requests in flight at redirect: both old words dropped
    instr_ready_I = 1'b1;
    resp_en = 1'b0;
    repeat (4) tick();
    chk("drop_outstanding", 32'(out_cnt), 32'd2);
    chk("drop_cap_valid", 32'(mem_addr_valid_O), 32'd0);
    redirect(32'h80);
    got.delete();
    issued.delete();
    resp_en = 1'b1;
    run_until(1, 20, "drop_timeout");
    chk("drop_first_pc", got_pc(0), 32'h80);
    chk("drop_first_instr", got_instr(0), word_at(32'h80));
    chk("drop_first_issue", (issued.size() > 0) ? issued[0] : 32'hBAD0_BAD0, 32'h80);

    // Redirect in the same cycle as a response: that word is not delivered
    repeat (4) tick();
    chk("sc_resp_pending", 32'(rsp_q.size() > 0), 32'd1);
    redirect(32'h500);
    chk("sc_data_hs", 32'(last_data_hs), 32'd1);
    got.delete();
    run_until(1, 20, "sc_timeout");
    chk("sc_first_pc", got_pc(0), 32'h500);
    chk("sc_first_instr", got_instr(0), word_at(32'h500));

    // Asynchronous reset mid-stream
    instr_ready_I = 1'b0;
    redirect(32'h600);
    repeat (4) tick();
    chk("mid_pre_count", 32'(count_O != 3'd0), 32'd1);
    rst_n = 1'b0;
    mem_data_valid_I = 1'b0;
    rsp_q.delete();
    out_cnt = 0;
    #1;
    chk("mid_rst_instr_valid", 32'(instr_valid_O), 32'd0);
    chk("mid_rst_addr_valid", 32'(mem_addr_valid_O), 32'd0);
    chk("mid_rst_count", 32'(count_O), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mid_post_pc_ready", 32'(pc_ready_O), 32'd1);
    chk("mid_post_addr_valid", 32'(mem_addr_valid_O), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
